// File: rtl/push_debounce_pkg.sv
// rtl/push_debounce_pkg.sv - shared constants, state encoding and helpers for push_debounce
package push_debounce_pkg;

    // Default timing at 50 MHz: 10 ms debounce, 0.5 s first repeat, 0.2 s repeat period.
    localparam int DEF_DB_CYCLES  = 500000;
    localparam int DEF_REP_DELAY  = 25000000;
    localparam int DEF_REP_PERIOD = 10000000;

    // Buttons are active-low, so the idle (released) level is one.
    localparam logic BTN_IDLE = 1'b1;

    typedef logic [1:0] db_state_t;

    localparam db_state_t ST_RELEASED     = 2'd0;
    localparam db_state_t ST_PRESS_PEND   = 2'd1;
    localparam db_state_t ST_PRESSED      = 2'd2;
    localparam db_state_t ST_RELEASE_PEND = 2'd3;

    // Width of a counter that must hold values up to max(a, b).
    function automatic int rep_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/push_debounce_if.sv
// rtl/push_debounce_if.sv - button bundle between board pins and the debouncer
//
// i_Push    : raw active-low button levels (asynchronous)
// o_Push    : debounced active-low level
// o_Press   : one-cycle pulse per accepted press (and repeat, if enabled)
// o_Release : one-cycle pulse per accepted release
// master drives the raw buttons; slave is the debouncer.
interface push_debounce_if #(
    parameter int N_BTN = 2
);
    logic [N_BTN-1:0] i_Push;
    logic [N_BTN-1:0] o_Push;
    logic [N_BTN-1:0] o_Press;
    logic [N_BTN-1:0] o_Release;

    modport master (
        output i_Push,
        input  o_Push,
        input  o_Press,
        input  o_Release
    );

    modport slave (
        input  i_Push,
        output o_Push,
        output o_Press,
        output o_Release
    );
endinterface

// File: rtl/push_debounce_debounce_cell.sv
// rtl/push_debounce_debounce_cell.sv - one-button synchroniser, debounce FSM and optional auto-repeat
//
// clk, resetn   : clock and synchronous active-low reset
// raw           : asynchronous active-low button
// level         : debounced active-low level (registered)
// press_pulse   : one-cycle pulse on accepted press / repeat (registered sources)
// release_pulse : one-cycle pulse on accepted release (registered)
// Optional: PUSH_DEBOUNCE_AUTOREPEAT_EN adds a repeat counter while PRESSED.
module debounce_cell
    import push_debounce_pkg::*;
#(
    parameter int DB_CYCLES  = DEF_DB_CYCLES,
    parameter int REP_DELAY  = DEF_REP_DELAY,
    parameter int REP_PERIOD = DEF_REP_PERIOD
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             press_acc;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1         <= BTN_IDLE;
            sync2         <= BTN_IDLE;
            state         <= ST_RELEASED;
            cnt           <= '0;
            level         <= BTN_IDLE;
            press_acc     <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync1         <= raw;
            sync2         <= sync1;
            press_acc     <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                ST_RELEASED: begin
                    if (!sync2) begin
                        state <= ST_PRESS_PEND;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                ST_PRESS_PEND: begin
                    if (sync2) begin
                        state <= ST_RELEASED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= ST_PRESSED;
                        cnt       <= '0;
                        level     <= 1'b0;
                        press_acc <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (sync2) begin
                        state <= ST_RELEASE_PEND;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                ST_RELEASE_PEND: begin
                    if (!sync2) begin
                        state <= ST_PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state         <= ST_RELEASED;
                        cnt           <= '0;
                        level         <= 1'b1;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= ST_RELEASED;
                    cnt   <= '0;
                    level <= BTN_IDLE;
                end
            endcase
        end
    end

`ifdef PUSH_DEBOUNCE_AUTOREPEAT_EN
    localparam int REP_W = rep_width(REP_DELAY, REP_PERIOD);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REP_DELAY - 1);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REP_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_run;   // first repeat already issued, use the period
    logic             rep_fire;

    // Counts edges spent holding in PRESSED; cleared the moment the FSM
    // leaves (or is about to leave) PRESSED so a re-press starts fresh.
    always_ff @(posedge clk) begin
        if (!resetn || state != ST_PRESSED || sync2) begin
            rep_cnt  <= '0;
            rep_run  <= 1'b0;
            rep_fire <= 1'b0;
        end else if (rep_cnt == (rep_run ? REP_NEXT : REP_FIRST)) begin
            rep_cnt  <= '0;
            rep_run  <= 1'b1;
            rep_fire <= 1'b1;
        end else begin
            rep_cnt  <= rep_cnt + REP_W'(1);
            rep_fire <= 1'b0;
        end
    end

    assign press_pulse = press_acc | rep_fire;
`else
    // Repeat timing has no effect when the feature is compiled out.
    logic unused_rep_cfg;
    assign unused_rep_cfg = ^{32'(REP_DELAY), 32'(REP_PERIOD)};
    assign press_pulse    = press_acc;
`endif

endmodule

// File: rtl/push_debounce.sv
// rtl/push_debounce.sv - N_BTN-channel push-button debouncer feeding the up/down counter
//
// i_Clk : system clock (rising edge)
// i_Rst : synchronous active-low reset
// btn   : push_debounce_if slave (i_Push in; o_Push, o_Press, o_Release out)
// Optional: PUSH_DEBOUNCE_AUTOREPEAT_EN enables press auto-repeat.
module push_debounce
    import push_debounce_pkg::*;
#(
    parameter int N_BTN      = 2,
    parameter int DB_CYCLES  = DEF_DB_CYCLES,
    parameter int REP_DELAY  = DEF_REP_DELAY,
    parameter int REP_PERIOD = DEF_REP_PERIOD
) (
    input logic            i_Clk,
    input logic            i_Rst,
    push_debounce_if.slave btn
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_cell #(
            .DB_CYCLES  (DB_CYCLES),
            .REP_DELAY  (REP_DELAY),
            .REP_PERIOD (REP_PERIOD)
        ) u_cell (
            .clk           (i_Clk),
            .resetn        (i_Rst),
            .raw           (btn.i_Push[i]),
            .level         (btn.o_Push[i]),
            .press_pulse   (btn.o_Press[i]),
            .release_pulse (btn.o_Release[i])
        );
    end

endmodule

// File: tb/tb_push_debounce.sv
// tb/tb_push_debounce.sv - directed self-checking bench for push_debounce
module tb_push_debounce;

    logic i_Clk = 1'b0;
    logic i_Rst;
    int   vectors = 0;
    int   miscompares = 0;

    push_debounce_if #(.N_BTN(2)) bus ();

    push_debounce #(
        .N_BTN      (2),
        .DB_CYCLES  (4),
        .REP_DELAY  (10),
        .REP_PERIOD (5)
    ) dut (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .btn   (bus)
    );

    always #5 i_Clk = ~i_Clk;

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic test_reset();
        logic [1:0] ep, epr;
        i_Rst = 1'b0;
        bus.i_Push = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus.o_Push !== 2'b11 || bus.o_Press !== 2'b00 || bus.o_Release !== 2'b00) begin
                miscompares++;
                $display("FAIL reset_hold cyc%0d: push=%b press=%b rel=%b, want 11/00/00",
                         i, bus.o_Push, bus.o_Press, bus.o_Release);
            end
        end
        i_Rst = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            ep  = (t >= 6) ? 2'b00 : 2'b11;
            epr = (t == 6) ? 2'b11 : 2'b00;
            vectors++;
            if (bus.o_Push !== ep || bus.o_Press !== epr) begin
                miscompares++;
                $display("FAIL reset_then_press t%0d: push=%b press=%b, want %b/%b",
                         t, bus.o_Push, bus.o_Press, ep, epr);
            end
        end
        bus.i_Push = 2'b11;
        repeat (7) tick();
    endtask

    task automatic test_clean_press();
        logic [1:0] ep, epr, er;
        bus.i_Push = 2'b01;
        for (int t = 1; t <= 7; t++) begin
            tick();
            ep  = (t >= 6) ? 2'b01 : 2'b11;
            epr = (t == 6) ? 2'b10 : 2'b00;
            vectors++;
            if (bus.o_Push !== ep || bus.o_Press !== epr || bus.o_Release !== 2'b00) begin
                miscompares++;
                $display("FAIL clean_press t%0d: push=%b press=%b rel=%b, want %b/%b/00",
                         t, bus.o_Push, bus.o_Press, bus.o_Release, ep, epr);
            end
        end
        bus.i_Push = 2'b11;
        for (int t = 1; t <= 7; t++) begin
            tick();
            ep = (t >= 6) ? 2'b11 : 2'b01;
            er = (t == 6) ? 2'b10 : 2'b00;
            vectors++;
            if (bus.o_Push !== ep || bus.o_Release !== er || bus.o_Press !== 2'b00) begin
                miscompares++;
                $display("FAIL clean_release t%0d: push=%b rel=%b press=%b, want %b/%b/00",
                         t, bus.o_Push, bus.o_Release, bus.o_Press, ep, er);
            end
        end
    endtask

    task automatic test_bounce();
        logic [10:0] pat;
        logic [1:0]  ep, epr;
        // bit0 levels per tick, LSB first: 0,0,0,1 then low for the rest
        pat = 11'b000_0000_1000;
        for (int t = 1; t <= 11; t++) begin
            bus.i_Push = {1'b1, pat[t-1]};
            tick();
            ep  = (t >= 10) ? 2'b10 : 2'b11;
            epr = (t == 10) ? 2'b01 : 2'b00;
            vectors++;
            if (bus.o_Push !== ep || bus.o_Press !== epr) begin
                miscompares++;
                $display("FAIL bounce t%0d: push=%b press=%b, want %b/%b",
                         t, bus.o_Push, bus.o_Press, ep, epr);
            end
        end
        bus.i_Push = 2'b11;
        repeat (7) tick();
        vectors++;
        if (bus.o_Push !== 2'b11) begin
            miscompares++;
            $display("FAIL bounce_release: push=%b, want 11", bus.o_Push);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] ep, er;
        bus.i_Push = 2'b00;
        repeat (5) tick();
        tick();
        vectors++;
        if (bus.o_Press !== 2'b11 || bus.o_Push !== 2'b00) begin
            miscompares++;
            $display("FAIL simul_press: press=%b push=%b, want 11/00", bus.o_Press, bus.o_Push);
        end
        repeat (2) tick();
        bus.i_Push = 2'b11;
        for (int t = 1; t <= 7; t++) begin
            tick();
            ep = (t >= 6) ? 2'b11 : 2'b00;
            er = (t == 6) ? 2'b11 : 2'b00;
            vectors++;
            if (bus.o_Push !== ep || bus.o_Release !== er || bus.o_Press !== 2'b00) begin
                miscompares++;
                $display("FAIL simul_release t%0d: push=%b rel=%b press=%b, want %b/%b/00",
                         t, bus.o_Push, bus.o_Release, bus.o_Press, ep, er);
            end
        end
    endtask

    task automatic test_reset_mid_pending();
        logic [1:0] ep, epr;
        bus.i_Push = 2'b10;
        for (int t = 1; t <= 5; t++) begin
            tick();
            vectors++;
            if (bus.o_Press !== 2'b00 || bus.o_Push !== 2'b11) begin
                miscompares++;
                $display("FAIL midpend_pre t%0d: press=%b push=%b, want 00/11",
                         t, bus.o_Press, bus.o_Push);
            end
        end
        i_Rst = 1'b0;
        tick();
        vectors++;
        if (bus.o_Press !== 2'b00 || bus.o_Push !== 2'b11) begin
            miscompares++;
            $display("FAIL midpend_rst: press=%b push=%b, want 00/11", bus.o_Press, bus.o_Push);
        end
        i_Rst = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            ep  = (t >= 6) ? 2'b10 : 2'b11;
            epr = (t == 6) ? 2'b01 : 2'b00;
            vectors++;
            if (bus.o_Push !== ep || bus.o_Press !== epr) begin
                miscompares++;
                $display("FAIL midpend_after t%0d: push=%b press=%b, want %b/%b",
                         t, bus.o_Push, bus.o_Press, ep, epr);
            end
        end
        bus.i_Push = 2'b11;
        repeat (7) tick();
    endtask

    task automatic test_autorepeat();
        logic [1:0] epr;
        bus.i_Push = 2'b01;
        repeat (5) tick();
        tick();
        vectors++;
        if (bus.o_Press !== 2'b10 || bus.o_Push !== 2'b01) begin
            miscompares++;
            $display("FAIL rep_accept: press=%b push=%b, want 10/01", bus.o_Press, bus.o_Push);
        end
        for (int j = 1; j <= 30; j++) begin
            tick();
`ifdef PUSH_DEBOUNCE_AUTOREPEAT_EN
            epr = (j == 10 || j == 15 || j == 20 || j == 25 || j == 30) ? 2'b10 : 2'b00;
`else
            epr = 2'b00;
`endif
            vectors++;
            if (bus.o_Press !== epr || bus.o_Push !== 2'b01) begin
                miscompares++;
                $display("FAIL rep_hold +%0d: press=%b push=%b, want %b/01",
                         j, bus.o_Press, bus.o_Push, epr);
            end
        end
        bus.i_Push = 2'b11;
        repeat (6) tick();
        vectors++;
        if (bus.o_Release !== 2'b10 || bus.o_Push !== 2'b11) begin
            miscompares++;
            $display("FAIL rep_release: rel=%b push=%b, want 10/11", bus.o_Release, bus.o_Push);
        end
        tick();
    endtask

    initial begin
        i_Rst = 1'b0;
        bus.i_Push = 2'b11;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid_pending();
        test_autorepeat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/push_debounce.md
Name: push_debounce

Overview:
Push-button conditioner that sits directly upstream of the up/down counter and feeds its i_Push input.
- Synchronises raw, bouncy, active-low board buttons into the i_Clk domain.
- Per button, a 4-state FSM filters bounces and emits a clean active-low level (counter-compatible) plus one-cycle press/release pulses.
- N_BTN independent channels; the counter uses N_BTN=2 (bit1=up, bit0=down).

Parameters:
N_BTN, 2, number of independent button channels
DB_CYCLES, 500000, consecutive agreeing samples required to accept a new level (10 ms at 50 MHz); legal range >= 2
CNT_W, $clog2(DB_CYCLES+1), debounce counter width (derived, not overridden)
REP_DELAY, 25000000, auto-repeat first-repeat delay in cycles (only used with the optional feature)
REP_PERIOD, 10000000, auto-repeat period in cycles (only used with the optional feature)

Ports:
i_Clk  input  1  system clock, all logic on rising edge
i_Rst  input  1  synchronous active-low reset, sampled on rising i_Clk
i_Push  input  N_BTN  raw button levels, active-low (0 = pressed), asynchronous
o_Push  output  N_BTN  debounced level, active-low, registered
o_Press  output  N_BTN  one-cycle high pulse on accepted press
o_Release  output  N_BTN  one-cycle high pulse on accepted release

Behaviour:
- Reset (i_Rst==0 at posedge):
  - both synchroniser stages all-ones;
  - every FSM in RELEASED;
  - counters = 0;
  - o_Push = all-ones; o_Press = 0; o_Release = 0.
  - Reset mid-pending discards the partial count; no pulse is emitted.
- Synchroniser: 2-flop chain per bit; FSM sees only sync2.
- Per-channel FSM, state encoding 2 bits:
  - RELEASED: sync2==0 -> PRESS_PEND, cnt=1; else stay, cnt=0.
  - PRESS_PEND: sync2==1 (bounce) -> RELEASED, cnt=0, no pulse. sync2==0 and cnt==DB_CYCLES-1 -> PRESSED, cnt=0, o_Push bit=0, o_Press bit=1 for that cycle. Otherwise cnt+1.
  - PRESSED: mirror of RELEASED (sync2==1 -> RELEASE_PEND, cnt=1).
  - RELEASE_PEND: mirror of PRESS_PEND; on acceptance -> RELEASED, o_Push bit=1, o_Release pulse.
- Latency: a clean edge first sampled at posedge k changes o_Push at posedge k+DB_CYCLES+1, i.e. DB_CYCLES+2 edges counting k. The pulse is asserted on that same edge and cleared on the next.
- o_Push, o_Press and o_Release are registered outputs with no combinational path from i_Push.
- Counter never exceeds DB_CYCLES-1; no wrap possible.
- Channels are fully independent; simultaneous presses on several bits each follow their own timing.
- o_Press and o_Release are never both high on one bit in one cycle.
- A glitch shorter than DB_CYCLES samples is never visible on the outputs.

Optional Feature:
PUSH_DEBOUNCE_AUTOREPEAT_EN
- Defined:
  - In PRESSED, a per-channel repeat counter runs.
  - o_Press re-pulses REP_DELAY cycles after acceptance, then every REP_PERIOD cycles, while the button stays held.
  - The counter clears on leaving PRESSED and on reset.
  - o_Push is unaffected.
- Undefined: no repeat counter is synthesised; exactly one o_Press pulse per accepted press.

Decomposition:
- push_debounce_pkg:
  - state typedef (RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND);
  - default DB_CYCLES/REP_DELAY/REP_PERIOD constants;
  - reset level constant for active-low buttons.
- Sub-module debounce_cell: one synchroniser + FSM + counter(s) for one bit. push_debounce generates N_BTN instances.

Test Plan:
All scenarios run with DB_CYCLES=4, REP_DELAY=10, REP_PERIOD=5, N_BTN=2.
1. Reset: hold i_Rst=0 with i_Push=2'b00 for 3 cycles -> o_Push=2'b11, o_Press=0, o_Release=0 throughout; after release of reset, press accepted 6 edges later.
2. Clean press: i_Push[1] 1->0 first sampled at edge k -> o_Push[1]=0 and o_Press[1]=1 at edge k+5 only; o_Press[1]=0 at k+6.
3. Bounce: i_Push[0] low 3 cycles, high 1, low 6 -> single o_Press[0] pulse 6 edges after the final falling sample; no earlier pulse.
4. Release and simultaneity: both bits pressed, then both released on the same cycle -> o_Release=2'b11 on the same edge, o_Push back to 2'b11.
5. Reset mid-pending: press held 3 edges into PRESS_PEND, then i_Rst=0 for 1 cycle -> no o_Press; after reset, press needs full DB_CYCLES+2 again.
6. With PUSH_DEBOUNCE_AUTOREPEAT_EN: hold bit1 for 30 cycles after acceptance -> o_Press[1] pulses at +0, +10, +15, +20, +25, +30; without the macro only at +0.
